// File: rtl/if_fetch_if.sv
// if_fetch_if: byte-serial memory fetch bus between if_fetch and the memory controller
interface if_fetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [7:0]  mem_byte;
  modport master(output mem_req, mem_addr, input mem_valid, mem_byte);
  modport slave(input mem_req, mem_addr, output mem_valid, mem_byte);
endinterface

// File: rtl/if_fetch.sv
// if_fetch: byte-serial instruction fetch stage; ICACHE_EN adds a direct-mapped I-cache
module if_fetch #(
  parameter int ICACHE_INDEX_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [31:0]       pc,
  output logic [31:0]       next_pc,
  output logic              stall_req,
  input  logic              flush,
  input  logic              id_stall,
  if_fetch_if.master        mem,
  output logic              if_valid,
  output logic [31:0]       if_inst,
  output logic [31:0]       if_pc
);
  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_e;
  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] byte_q, byte_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        last, hit;
  logic [31:0] hit_data;
  assign last = state_q == FETCH && mem.mem_valid && cnt_q == 2'd3;
`ifdef ICACHE_EN
  localparam int LINES = 1 << ICACHE_INDEX_W;
  localparam int TAG_W = 32 - ICACHE_INDEX_W - 2;
  logic [LINES-1:0]          valid_q;
  logic [TAG_W-1:0]          tag_q [LINES];
  logic [31:0]               data_q [LINES];
  logic [ICACHE_INDEX_W-1:0] rd_idx, wr_idx;
  logic                      fill;
  assign rd_idx   = pc[ICACHE_INDEX_W+1:2];
  assign wr_idx   = fetch_pc_q[ICACHE_INDEX_W+1:2];
  assign hit      = valid_q[rd_idx] && tag_q[rd_idx] == pc[31:ICACHE_INDEX_W+2];
  assign hit_data = data_q[rd_idx];
  assign fill     = rdy && !flush && last;
  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else if (fill) valid_q[wr_idx] <= 1'b1;
  end
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[wr_idx]  <= fetch_pc_q[31:ICACHE_INDEX_W+2];
      data_q[wr_idx] <= {mem.mem_byte, byte_q};
    end
  end
`else
  logic unused_w;
  assign unused_w = ICACHE_INDEX_W != 0;
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif
  assign next_pc   = fetch_pc_q + 32'd4;
  assign stall_req = !(state_q == DONE && !id_stall);
  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;
  assign if_valid = if_valid_q;
  assign if_inst  = if_inst_q;
  assign if_pc    = if_pc_q;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    byte_d     = byte_q;
    fetch_pc_d = fetch_pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    if_valid_d = if_valid_q;
    if_inst_d  = if_inst_q;
    if_pc_d    = if_pc_q;
    if (rdy && flush) begin
      state_d    = IDLE;
      mem_req_d  = 1'b0;
      if_valid_d = 1'b0;
      cnt_d      = '0;
    end else if (rdy) begin
      case (state_q)
        IDLE: begin
          fetch_pc_d = pc;
          cnt_d      = '0;
          if (hit) begin
            if_inst_d  = hit_data;
            if_pc_d    = pc;
            if_valid_d = 1'b1;
            state_d    = DONE;
          end else begin
            mem_addr_d = pc;
            mem_req_d  = 1'b1;
            state_d    = FETCH;
          end
        end
        FETCH: if (mem.mem_valid) begin
          cnt_d  = cnt_q + 2'd1;
          byte_d = cnt_q == 2'd0 ? {byte_q[23:8], mem.mem_byte} :
                   cnt_q == 2'd1 ? {byte_q[23:16], mem.mem_byte, byte_q[7:0]} :
                                   {mem.mem_byte, byte_q[15:0]};
          if (last) begin
            if_inst_d  = {mem.mem_byte, byte_q};
            if_pc_d    = fetch_pc_q;
            if_valid_d = 1'b1;
            mem_req_d  = 1'b0;
            state_d    = DONE;
          end
        end
        DONE: if (!id_stall) begin
          if_valid_d = 1'b0;
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      byte_q     <= '0;
      fetch_pc_q <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      if_valid_q <= 1'b0;
      if_inst_q  <= '0;
      if_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byte_q     <= byte_d;
      fetch_pc_q <= fetch_pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      if_valid_q <= if_valid_d;
      if_inst_q  <= if_inst_d;
      if_pc_q    <= if_pc_d;
    end
  end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed self-checking bench for if_fetch
module tb_if_fetch;
  logic        clk = 1'b0;
  logic        rst, rdy, flush, id_stall;
  logic [31:0] pc, next_pc, if_inst, if_pc;
  logic        stall_req, if_valid;
  int          checks = 0;
  int          errors = 0;
  if_fetch_if mem_if();
  if_fetch dut (
    .clk(clk), .rst(rst), .rdy(rdy), .pc(pc), .next_pc(next_pc),
    .stall_req(stall_req), .flush(flush), .id_stall(id_stall), .mem(mem_if),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic beat(input logic [7:0] b, input int gap);
    mem_if.mem_valid = 1'b0;
    repeat (gap) tick();
    mem_if.mem_valid = 1'b1;
    mem_if.mem_byte  = b;
    tick();
    mem_if.mem_valid = 1'b0;
  endtask
  initial begin
    rst = 1'b1; rdy = 1'b1; pc = '0; flush = 1'b0; id_stall = 1'b0;
    mem_if.mem_valid = 1'b0; mem_if.mem_byte = '0;
    tick(); tick();
    chk("rst_req", mem_if.mem_req, 0);
    chk("rst_addr", mem_if.mem_addr, 0);
    chk("rst_valid", if_valid, 0);
    chk("rst_inst", if_inst, 0);
    chk("rst_pc", if_pc, 0);
    chk("rst_stall", stall_req, 1);
    chk("rst_next_pc", next_pc, 32'h4);
    rst = 1'b0;
    tick();
    chk("f0_req", mem_if.mem_req, 1);
    chk("f0_addr", mem_if.mem_addr, 0);
    beat(8'h13, 0); beat(8'h05, 0); beat(8'h10, 0); beat(8'h00, 0);
    chk("f0_valid", if_valid, 1);
    chk("f0_inst", if_inst, 32'h00100513);
    chk("f0_pc", if_pc, 0);
    chk("f0_next_pc", next_pc, 32'h4);
    chk("f0_stall", stall_req, 0);
    chk("f0_req_drop", mem_if.mem_req, 0);
    pc = 32'h4;
    tick();
    chk("f0_handoff_valid", if_valid, 0);
    chk("f0_idle_stall", stall_req, 1);
    tick();
    chk("f1_req", mem_if.mem_req, 1);
    chk("f1_addr", mem_if.mem_addr, 32'h4);
    id_stall = 1'b1;
    beat(8'hB3, 2); beat(8'h81, 2); beat(8'h20, 2); beat(8'h00, 2);
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", if_valid, 1);
      chk("stall_inst", if_inst, 32'h002081B3);
      chk("stall_req_hi", stall_req, 1);
      tick();
    end
    mem_if.mem_valid = 1'b1; mem_if.mem_byte = 8'h55;
    tick();
    mem_if.mem_valid = 1'b0;
    chk("stray_inst", if_inst, 32'h002081B3);
    chk("stray_pc", if_pc, 32'h4);
    id_stall = 1'b0;
    #1;
    chk("handoff_stall_lo", stall_req, 0);
    pc = 32'h100;
    tick();
    chk("handoff_valid", if_valid, 0);
    tick();
    chk("f100_addr", mem_if.mem_addr, 32'h100);
    beat(8'h01, 0); beat(8'h02, 1);
    flush = 1'b1; pc = 32'h200;
    tick();
    flush = 1'b0;
    chk("flush_req_lo", mem_if.mem_req, 0);
    chk("flush_valid", if_valid, 0);
    tick();
    chk("f200_req", mem_if.mem_req, 1);
    chk("f200_addr", mem_if.mem_addr, 32'h200);
    beat(8'hA1, 0); beat(8'hA2, 0); beat(8'hA3, 0);
    mem_if.mem_valid = 1'b1; mem_if.mem_byte = 8'hA4; flush = 1'b1; pc = 32'h300;
    tick();
    mem_if.mem_valid = 1'b0; flush = 1'b0;
    chk("flush4_valid", if_valid, 0);
    chk("flush4_req", mem_if.mem_req, 0);
    tick();
    chk("f300_req", mem_if.mem_req, 1);
    chk("f300_addr", mem_if.mem_addr, 32'h300);
    chk("f300_no_valid", if_valid, 0);
    beat(8'h11, 0); beat(8'h22, 0); beat(8'h33, 0); beat(8'h44, 0);
    chk("f300_valid", if_valid, 1);
    chk("f300_inst", if_inst, 32'h44332211);
    chk("f300_pc", if_pc, 32'h300);
    flush = 1'b1; pc = 32'h400;
    tick();
    flush = 1'b0;
    chk("flush_done_valid", if_valid, 0);
    chk("flush_done_req", mem_if.mem_req, 0);
    tick();
    chk("f400_req", mem_if.mem_req, 1);
    chk("f400_addr", mem_if.mem_addr, 32'h400);
    beat(8'hAA, 0); beat(8'hBB, 0);
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mem_if.mem_valid = i[0] ? 1'b0 : 1'b1;
      mem_if.mem_byte  = 8'hEE;
      tick();
      chk("rdy_req", mem_if.mem_req, 1);
      chk("rdy_valid", if_valid, 0);
    end
    mem_if.mem_valid = 1'b0; rdy = 1'b1;
    beat(8'hCC, 0); beat(8'hDD, 0);
    chk("rdy_resume_valid", if_valid, 1);
    chk("rdy_resume_inst", if_inst, 32'hDDCCBBAA);
    chk("rdy_resume_pc", if_pc, 32'h400);
    chk("rdy_next_pc", next_pc, 32'h404);
    pc = 32'hFFFFFFFC;
    tick(); tick();
    chk("wrap_addr", mem_if.mem_addr, 32'hFFFFFFFC);
    chk("wrap_next_pc", next_pc, 32'h0);
`ifdef ICACHE_EN
    flush = 1'b1; pc = 32'h40;
    tick();
    flush = 1'b0;
    tick();
    chk("c40_miss_req", mem_if.mem_req, 1);
    chk("c40_miss_addr", mem_if.mem_addr, 32'h40);
    beat(8'h01, 0); beat(8'h02, 0); beat(8'h03, 0); beat(8'h04, 0);
    chk("c40_inst", if_inst, 32'h04030201);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    chk("c40_hit_valid", if_valid, 1);
    chk("c40_hit_req", mem_if.mem_req, 0);
    chk("c40_hit_inst", if_inst, 32'h04030201);
    chk("c40_hit_pc", if_pc, 32'h40);
    flush = 1'b1; pc = 32'h140;
    tick();
    flush = 1'b0;
    tick();
    chk("c140_miss_req", mem_if.mem_req, 1);
    chk("c140_miss_addr", mem_if.mem_addr, 32'h140);
    beat(8'h05, 0); beat(8'h06, 0); beat(8'h07, 0); beat(8'h08, 0);
    chk("c140_inst", if_inst, 32'h08070605);
    flush = 1'b1; pc = 32'h40;
    tick();
    flush = 1'b0;
    tick();
    chk("c40_evicted_req", mem_if.mem_req, 1);
    chk("c40_evicted_valid", if_valid, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
